// File: rtl/lieat_exu_wbu_nch_pkg.sv
// Shared constants for the N-channel writeback unit.
package lieat_exu_wbu_nch_pkg;
  localparam int WBU_XLEN        = 32;
  localparam int WBU_REG_IDX     = 5;
  localparam int WBU_ARB_FIXED   = 0;
  localparam int WBU_ARB_RR      = 1;
  localparam int WBU_SIDE_MMIO   = 0;
  localparam int WBU_SIDE_EBREAK = 1;
  // Starvation counter width; covers STARVE_MAX up to 15.
  localparam int WBU_STARVE_W    = 4;
endpackage

// File: rtl/lieat_exu_wbu_nch_if.sv
// Channel inputs and writeback output bundle.
// master = the writeback unit, slave = the surrounding exu/regfile side.
interface lieat_exu_wbu_nch_if #(
  parameter int NCH     = 3,
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5,
  parameter int SIDE_W  = 2
);
  logic [NCH-1:0]         ch_valid;
  logic [NCH-1:0]         ch_ready;
  logic [NCH*XLEN-1:0]    ch_pc;
  logic [NCH-1:0]         ch_en;
  logic [NCH*REG_IDX-1:0] ch_rd;
  logic [NCH*XLEN-1:0]    ch_data;
  logic [NCH*SIDE_W-1:0]  ch_side;
  logic                   wbck_o_valid;
  logic                   wbck_o_ready;
  logic [NCH-1:0]         wbck_o_op;
  logic [XLEN-1:0]        wbck_o_pc;
  logic                   wbck_o_en;
  logic [REG_IDX-1:0]     wbck_o_rd;
  logic [XLEN-1:0]        wbck_o_data;
  logic [SIDE_W-1:0]      wbck_o_side;

  modport master (
    input  ch_valid, ch_pc, ch_en, ch_rd, ch_data, ch_side, wbck_o_ready,
    output ch_ready, wbck_o_valid, wbck_o_op, wbck_o_pc, wbck_o_en,
           wbck_o_rd, wbck_o_data, wbck_o_side
  );
  modport slave (
    output ch_valid, ch_pc, ch_en, ch_rd, ch_data, ch_side, wbck_o_ready,
    input  ch_ready, wbck_o_valid, wbck_o_op, wbck_o_pc, wbck_o_en,
           wbck_o_rd, wbck_o_data, wbck_o_side
  );
endinterface

// File: rtl/lieat_wbu_arbiter.sv
// Writeback channel arbiter: fixed priority with starvation promotion,
// or round-robin. Grant is one-hot or zero and depends only on state + ch_valid.
module lieat_wbu_arbiter
  import lieat_exu_wbu_nch_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int ARB_MODE   = WBU_ARB_FIXED,
  parameter int STARVE_MAX = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] ch_valid,
  input  logic           accept,
  output logic [NCH-1:0] grant
);
  localparam int PW = $clog2(NCH);
  localparam logic [WBU_STARVE_W-1:0] SMAX = WBU_STARVE_W'(STARVE_MAX);

  logic [PW-1:0]                       rr_ptr_q, rr_ptr_d, win, idx;
  logic [NCH-1:0][WBU_STARVE_W-1:0]    cnt_q, cnt_d;
  logic [NCH-1:0]                      starved, pool;
  logic                                found, hs;
  int                                  s;

  // Grant selection: rotating search from rr_ptr, or highest index within
  // the starved set (falling back to all valid channels when none starve).
  always_comb begin
    grant   = '0;
    starved = '0;
    pool    = '0;
    found   = 1'b0;
    s       = 0;
    idx     = '0;
    for (int i = 0; i < NCH; i++)
      starved[i] = (STARVE_MAX != 0) && ch_valid[i] && (cnt_q[i] == SMAX);
    if (ARB_MODE == WBU_ARB_RR) begin
      for (int k = 0; k < NCH; k++) begin
        s = int'(rr_ptr_q) + k;
        if (s >= NCH) s = s - NCH;
        idx = PW'(s);
        if (!found && ch_valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end else begin
      pool = (|starved) ? starved : ch_valid;
      for (int i = 0; i < NCH; i++)
        if (pool[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
    end
  end

  // Next pointer / starvation counters; nothing advances while accept is low.
  always_comb begin
    hs  = accept & (|grant);
    win = '0;
    for (int i = 0; i < NCH; i++)
      if (grant[i]) win = PW'(i);
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == WBU_ARB_RR && hs)
      rr_ptr_d = (win == PW'(NCH - 1)) ? '0 : win + PW'(1);
    cnt_d = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (ARB_MODE == WBU_ARB_RR || !ch_valid[i])
        cnt_d[i] = '0;
      else if (accept) begin
        if (grant[i])
          cnt_d[i] = '0;
        else if (cnt_q[i] != SMAX)
          cnt_d[i] = cnt_q[i] + WBU_STARVE_W'(1);
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/lieat_exu_wbu_nch.sv
// N-channel writeback unit: arbitrates result channels into one registered
// writeback port with backpressure and x0-write suppression.
module lieat_exu_wbu_nch
  import lieat_exu_wbu_nch_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int XLEN       = WBU_XLEN,
  parameter int REG_IDX    = WBU_REG_IDX,
  parameter int SIDE_W     = 2,
  parameter int ARB_MODE   = WBU_ARB_FIXED,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  lieat_exu_wbu_nch_if.master wb
);
  logic               accept, hs;
  logic [NCH-1:0]     grant;
  logic [XLEN-1:0]    sel_pc, sel_data;
  logic               sel_en;
  logic [REG_IDX-1:0] sel_rd;
  logic [SIDE_W-1:0]  sel_side;

  logic               valid_q, valid_d, en_q, en_d;
  logic [NCH-1:0]     op_q, op_d;
  logic [XLEN-1:0]    pc_q, pc_d, data_q, data_d;
  logic [REG_IDX-1:0] rd_q, rd_d;
  logic [SIDE_W-1:0]  side_q, side_d;

  // Output slot can take a new entry when empty or draining this cycle.
  assign accept      = ~valid_q | wb.wbck_o_ready;
  assign wb.ch_ready = grant & {NCH{accept}};
  assign hs          = |(wb.ch_valid & wb.ch_ready);

  lieat_wbu_arbiter #(
    .NCH(NCH), .ARB_MODE(ARB_MODE), .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clock(clock), .reset(reset), .ch_valid(wb.ch_valid),
    .accept(accept), .grant(grant)
  );

  // One-hot AND-OR payload mux driven by the grant.
  always_comb begin
    sel_pc   = '0;
    sel_data = '0;
    sel_en   = 1'b0;
    sel_rd   = '0;
    sel_side = '0;
    for (int i = 0; i < NCH; i++)
      if (grant[i]) begin
        sel_pc   = sel_pc   | wb.ch_pc[i*XLEN +: XLEN];
        sel_data = sel_data | wb.ch_data[i*XLEN +: XLEN];
        sel_en   = sel_en   | wb.ch_en[i];
        sel_rd   = sel_rd   | wb.ch_rd[i*REG_IDX +: REG_IDX];
        sel_side = sel_side | wb.ch_side[i*SIDE_W +: SIDE_W];
      end
  end

  // Output register next state: load on handshake, otherwise drain or hold.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    pc_d    = pc_q;
    en_d    = en_q;
    rd_d    = rd_q;
    data_d  = data_q;
    side_d  = side_q;
    if (hs) begin
      valid_d = 1'b1;
      op_d    = grant;
      pc_d    = sel_pc;
      en_d    = sel_en & (sel_rd != '0);  // writes to x0 are dropped
      rd_d    = sel_rd;
      data_d  = sel_data;
      side_d  = sel_side;
    end else if (wb.wbck_o_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      pc_q    <= '0;
      en_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      side_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      side_q  <= side_d;
    end
  end

  assign wb.wbck_o_valid = valid_q;
  assign wb.wbck_o_op    = op_q;
  assign wb.wbck_o_pc    = pc_q;
  assign wb.wbck_o_en    = en_q;
  assign wb.wbck_o_rd    = rd_q;
  assign wb.wbck_o_data  = data_q;
  assign wb.wbck_o_side  = side_q;
endmodule

// File: tb/tb_lieat_exu_wbu_nch.sv
// Directed bench: a fixed-priority and a round-robin instance share clock/reset.
module tb_lieat_exu_wbu_nch;
  import lieat_exu_wbu_nch_pkg::*;
  localparam int NCH = 3;

  logic clock, reset;
  int   total, bad;

  lieat_exu_wbu_nch_if #(.NCH(NCH)) fi();
  lieat_exu_wbu_nch_if #(.NCH(NCH)) ri();

  lieat_exu_wbu_nch #(.NCH(NCH), .ARB_MODE(WBU_ARB_FIXED), .STARVE_MAX(4))
    u_fix (.clock(clock), .reset(reset), .wb(fi));
  lieat_exu_wbu_nch #(.NCH(NCH), .ARB_MODE(WBU_ARB_RR), .STARVE_MAX(4))
    u_rr  (.clock(clock), .reset(reset), .wb(ri));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Channel i: pc=0x100+4i, data=0xD0+i, rd=i+1, side=i+1, en=1.
  task automatic init_payload();
    fi.ch_valid = '0; ri.ch_valid = '0;
    fi.wbck_o_ready = 1'b1; ri.wbck_o_ready = 1'b1;
    fi.ch_en = '1; ri.ch_en = '1;
    for (int i = 0; i < NCH; i++) begin
      fi.ch_pc[i*32 +: 32]   = 32'h100 + 32'(4*i);
      fi.ch_data[i*32 +: 32] = 32'hD0 + 32'(i);
      fi.ch_rd[i*5 +: 5]     = 5'(i+1);
      fi.ch_side[i*2 +: 2]   = 2'(i+1);
      ri.ch_pc[i*32 +: 32]   = 32'h100 + 32'(4*i);
      ri.ch_data[i*32 +: 32] = 32'hD0 + 32'(i);
      ri.ch_rd[i*5 +: 5]     = 5'(i+1);
      ri.ch_side[i*2 +: 2]   = 2'(i+1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    init_payload();
    #3;
    total++; if (fi.wbck_o_valid !== 1'b0) begin bad++; $display("FAIL rst_fix_valid got=%b exp=0", fi.wbck_o_valid); end
    total++; if (fi.wbck_o_op !== 3'b000 || fi.wbck_o_data !== 32'h0 || fi.wbck_o_pc !== 32'h0) begin bad++; $display("FAIL rst_fix_payload op=%b data=%h pc=%h exp=0", fi.wbck_o_op, fi.wbck_o_data, fi.wbck_o_pc); end
    total++; if (ri.wbck_o_valid !== 1'b0 || ri.wbck_o_op !== 3'b000) begin bad++; $display("FAIL rst_rr_out valid=%b op=%b exp=0", ri.wbck_o_valid, ri.wbck_o_op); end
    @(negedge clock); reset = 1'b0;
    tick();
    total++; if (fi.wbck_o_valid !== 1'b0 || fi.ch_ready !== 3'b000) begin bad++; $display("FAIL rst_idle valid=%b ready=%b exp=0", fi.wbck_o_valid, fi.ch_ready); end
  endtask

  task automatic test_fixed_prio();
    fi.ch_valid = 3'b111;
    @(negedge clock);
    total++; if (fi.ch_ready !== 3'b100) begin bad++; $display("FAIL fix_ready got=%b exp=100", fi.ch_ready); end
    tick(); fi.ch_valid = 3'b000;
    total++; if (fi.wbck_o_valid !== 1'b1 || fi.wbck_o_op !== 3'b100) begin bad++; $display("FAIL fix_out valid=%b op=%b exp=1/100", fi.wbck_o_valid, fi.wbck_o_op); end
    total++; if (fi.wbck_o_pc !== 32'h108 || fi.wbck_o_data !== 32'hD2 || fi.wbck_o_rd !== 5'd3 || fi.wbck_o_en !== 1'b1 || fi.wbck_o_side !== 2'b11) begin
      bad++; $display("FAIL fix_payload pc=%h data=%h rd=%0d en=%b side=%b exp=108/D2/3/1/11", fi.wbck_o_pc, fi.wbck_o_data, fi.wbck_o_rd, fi.wbck_o_en, fi.wbck_o_side); end
    @(negedge clock);
    total++; if (fi.ch_ready !== 3'b000) begin bad++; $display("FAIL fix_novalid_ready got=%b exp=000", fi.ch_ready); end
    tick();
    total++; if (fi.wbck_o_valid !== 1'b0 || fi.wbck_o_data !== 32'hD2) begin bad++; $display("FAIL fix_drain valid=%b data=%h exp=0/D2", fi.wbck_o_valid, fi.wbck_o_data); end
  endtask

  task automatic test_x0();
    fi.ch_rd[4:0] = 5'd0; fi.ch_data[31:0] = 32'hDEAD; fi.ch_valid = 3'b001;
    @(negedge clock);
    total++; if (fi.ch_ready !== 3'b001) begin bad++; $display("FAIL x0_ready got=%b exp=001", fi.ch_ready); end
    tick(); fi.ch_valid = 3'b000;
    total++; if (fi.wbck_o_en !== 1'b0 || fi.wbck_o_rd !== 5'd0 || fi.wbck_o_data !== 32'hDEAD || fi.wbck_o_op !== 3'b001) begin
      bad++; $display("FAIL x0_out en=%b rd=%0d data=%h op=%b exp=0/0/DEAD/001", fi.wbck_o_en, fi.wbck_o_rd, fi.wbck_o_data, fi.wbck_o_op); end
    fi.ch_rd[4:0] = 5'd1; fi.ch_data[31:0] = 32'hD0;
    tick();
  endtask

  task automatic test_backpressure();
    fi.ch_valid = 3'b010;
    tick();
    fi.ch_valid = 3'b100; fi.wbck_o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      total++; if (fi.ch_ready !== 3'b000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=000", k, fi.ch_ready); end
      tick();
      total++; if (fi.wbck_o_valid !== 1'b1 || fi.wbck_o_data !== 32'hD1 || fi.wbck_o_op !== 3'b010) begin
        bad++; $display("FAIL bp_hold[%0d] valid=%b data=%h op=%b exp=1/D1/010", k, fi.wbck_o_valid, fi.wbck_o_data, fi.wbck_o_op); end
    end
    fi.wbck_o_ready = 1'b1;
    @(negedge clock);
    total++; if (fi.ch_ready !== 3'b100) begin bad++; $display("FAIL bp_release_ready got=%b exp=100", fi.ch_ready); end
    tick(); fi.ch_valid = 3'b000;
    total++; if (fi.wbck_o_valid !== 1'b1 || fi.wbck_o_data !== 32'hD2 || fi.wbck_o_op !== 3'b100) begin
      bad++; $display("FAIL bp_reload valid=%b data=%h op=%b exp=1/D2/100", fi.wbck_o_valid, fi.wbck_o_data, fi.wbck_o_op); end
    tick();
  endtask

  task automatic test_starvation();
    logic [2:0] exp_g [0:6];
    exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100, 3'b100};
    fi.ch_valid = 3'b101;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      total++; if (fi.ch_ready !== exp_g[k]) begin bad++; $display("FAIL starve_ready[%0d] got=%b exp=%b", k, fi.ch_ready, exp_g[k]); end
      tick();
      total++; if (fi.wbck_o_op !== exp_g[k] || fi.wbck_o_valid !== 1'b1) begin bad++; $display("FAIL starve_op[%0d] got=%b exp=%b", k, fi.wbck_o_op, exp_g[k]); end
    end
    fi.ch_valid = 3'b000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [0:5];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    ri.ch_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      total++; if (ri.ch_ready !== exp_g[k]) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, ri.ch_ready, exp_g[k]); end
      tick();
      total++; if (ri.wbck_o_op !== exp_g[k] || ri.wbck_o_valid !== 1'b1) begin bad++; $display("FAIL rr_op[%0d] got=%b valid=%b exp=%b/1", k, ri.wbck_o_op, ri.wbck_o_valid, exp_g[k]); end
    end
    ri.ch_valid = 3'b000;
    tick();
  endtask

  task automatic test_async_reset();
    ri.ch_valid = 3'b001; fi.ch_valid = 3'b100;
    tick();
    ri.ch_valid = 3'b000; fi.ch_valid = 3'b000;
    total++; if (ri.wbck_o_valid !== 1'b1) begin bad++; $display("FAIL arst_pre valid=%b exp=1", ri.wbck_o_valid); end
    #2 reset = 1'b1;
    #1;
    total++; if (ri.wbck_o_valid !== 1'b0 || ri.wbck_o_op !== 3'b000 || ri.wbck_o_pc !== 32'h0 || ri.wbck_o_data !== 32'h0 || ri.wbck_o_rd !== 5'd0 || ri.wbck_o_en !== 1'b0 || ri.wbck_o_side !== 2'b00) begin
      bad++; $display("FAIL arst_rr_clear valid=%b op=%b pc=%h data=%h rd=%0d en=%b side=%b exp=0", ri.wbck_o_valid, ri.wbck_o_op, ri.wbck_o_pc, ri.wbck_o_data, ri.wbck_o_rd, ri.wbck_o_en, ri.wbck_o_side); end
    total++; if (fi.wbck_o_valid !== 1'b0 || fi.wbck_o_data !== 32'h0) begin bad++; $display("FAIL arst_fix_clear valid=%b data=%h exp=0", fi.wbck_o_valid, fi.wbck_o_data); end
    @(negedge clock); reset = 1'b0;
    ri.ch_valid = 3'b111;
    #1;
    total++; if (ri.ch_ready !== 3'b001) begin bad++; $display("FAIL arst_first_grant got=%b exp=001", ri.ch_ready); end
    tick();
    total++; if (ri.wbck_o_op !== 3'b001 || ri.wbck_o_valid !== 1'b1) begin bad++; $display("FAIL arst_first_op got=%b exp=001", ri.wbck_o_op); end
    ri.ch_valid = 3'b001;
    @(negedge clock);
    total++; if (ri.ch_ready !== 3'b001) begin bad++; $display("FAIL rr_wrap_search got=%b exp=001", ri.ch_ready); end
    tick();
    total++; if (ri.wbck_o_op !== 3'b001 || ri.wbck_o_data !== 32'hD0) begin bad++; $display("FAIL rr_wrap_op op=%b data=%h exp=001/D0", ri.wbck_o_op, ri.wbck_o_data); end
    ri.ch_valid = 3'b000;
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_fixed_prio();
    test_x0();
    test_backpressure();
    test_starvation();
    test_round_robin();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lieat_exu_wbu_nch.md
Name: lieat_exu_wbu_nch

Overview:
Parametrised N-channel writeback unit. It arbitrates NCH execution-result channels (com, lsu, muldiv, and future FPU/CSR units) into one registered writeback port toward the regfile, OITF and DPIC commit.
- Successor to the fixed 3-channel WBU.
- Adds downstream backpressure (wbck_o_ready).
- Adds selectable fixed-priority or round-robin arbitration.
- Adds starvation promotion in fixed mode and x0-write suppression.

Parameters:
NCH, 3, number of input channels (2..8); higher index = higher fixed priority (0=com, 1=lsu, 2=muldiv)
XLEN, 32, data/pc width
REG_IDX, 5, register index width
SIDE_W, 2, per-channel sideband bits (bit0=mmio, bit1=ebreak), passed through untouched
ARB_MODE, 0, 0 = fixed priority, 1 = round-robin
STARVE_MAX, 4, fixed-mode denial count that promotes a channel (1..15; 0 disables promotion)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high
ch_valid  in  NCH  per-channel result valid
ch_ready  out  NCH  per-channel accept
ch_pc  in  NCH*XLEN  channel i at [i*XLEN +: XLEN]
ch_en  in  NCH  regfile write enable
ch_rd  in  NCH*REG_IDX  destination register
ch_data  in  NCH*XLEN  write data
ch_side  in  NCH*SIDE_W  sideband
wbck_o_valid  out  1  output register valid
wbck_o_ready  in  1  downstream accept
wbck_o_op  out  NCH  one-hot source channel
wbck_o_pc  out  XLEN  pc of written-back instruction
wbck_o_en  out  1  effective write enable
wbck_o_rd  out  REG_IDX  destination
wbck_o_data  out  XLEN  data
wbck_o_side  out  SIDE_W  sideband of granted channel

Behaviour:
- Interface: one clock, `clock`. `reset` is asynchronous and active-high. All flops use lieat_general_dfflr-style async clear.
- Reset state: all outputs zero; rr_ptr=0; starvation counters = 0.
- Accept condition: accept = ~wbck_o_valid | wbck_o_ready, giving a full-throughput single-stage pipe register.
- Grant and ready:
  - grant is one-hot or zero, computed combinationally from ch_valid.
  - ch_ready[i] = grant[i] & accept.
  - Handshake hs = |(ch_valid & ch_ready).
  - ch_ready is never asserted for an invalid channel.
- Output register update:
  - On hs: load wbck_o_* from the granted channel and set wbck_o_valid=1. wbck_o_op = grant.
  - Else if wbck_o_ready: clear wbck_o_valid. Payload holds its last value.
  - Else: hold everything.
  - Latency is 1 cycle from hs to wbck_o_valid.
- x0 suppression: wbck_o_en = ch_en & (ch_rd != 0). wbck_o_rd is still passed through.
- Sideband: wbck_o_side is copied from the winner with no masking.
- Fixed mode (ARB_MODE=0):
  - The highest-index valid channel wins.
  - Promotion: starve_cnt[i] increments (saturating at STARVE_MAX) each cycle that ch_valid[i] & accept & ~grant[i].
  - It clears on grant[i], or when ch_valid[i]=0.
  - Any channel with starve_cnt==STARVE_MAX outranks all non-starved channels. Among starved channels, the highest index wins.
  - Counters do not advance while accept=0, so a stalled output never creates starvation.
- Round-robin mode (ARB_MODE=1):
  - The search starts at rr_ptr and ascends modulo NCH; the first valid channel wins.
  - On hs, rr_ptr <= (winner+1) mod NCH. rr_ptr is unchanged without hs.
  - Starvation counters are unused and held at 0.
- Boundary conditions:
  - No valid channel: grant=0, no hs; wbck_o_valid drops if wbck_o_ready.
  - Simultaneous drain and load (wbck_o_valid & wbck_o_ready & hs): valid stays 1 and the new payload loads.
  - wbck_o_ready=0 with wbck_o_valid=1: all ch_ready=0; rr_ptr and counters frozen.
  - Reset asserted mid-transfer clears everything immediately. A pending hs is lost; upstream must re-present.
  - rr_ptr wraps from NCH-1 to 0. NCH that is not a power of two must wrap correctly (e.g. NCH=3: 2 -> 0).

Decomposition:
- Shared defines header: `XLEN, `REG_IDX, and constants WBU_ARB_FIXED=0, WBU_ARB_RR=1, WBU_SIDE_MMIO=0, WBU_SIDE_EBREAK=1.
- One sub-module, lieat_wbu_arbiter (NCH, ARB_MODE, STARVE_MAX). It holds the grant logic, rr_ptr and starvation counters.
- The top contains the payload one-hot muxes, the output register and x0 suppression.

Test Plan:
- Fixed mode, NCH=3, ch_valid=3'b111 held for 1 cycle, wbck_o_ready=1 -> ch_ready=3'b100; next cycle wbck_o_op=3'b100 and wbck_o_valid=1.
- x0 suppression: ch0 valid, en=1, rd=0, data=32'hDEAD -> wbck_o_en=0, wbck_o_rd=0, wbck_o_data=32'hDEAD.
- Backpressure: output valid, wbck_o_ready=0 for 3 cycles, ch2 valid -> ch_ready=0 throughout, payload stable. Raising ready loads ch2 the same cycle, and valid stays 1.
- Starvation, STARVE_MAX=4: ch2 and ch0 valid continuously -> ch2 wins for 4 cycles, ch0 wins on the 5th, then ch2 resumes.
- Round-robin, NCH=3, all valid for 6 cycles -> grant order 0,1,2,0,1,2; rr_ptr wraps 2 -> 0.
- Reset asserted asynchronously mid-cycle while wbck_o_valid=1 -> all outputs 0 before the next edge, rr_ptr=0; first grant after release is ch0 in RR mode.
